// File: rtl/controle_pkg.sv
// Shared codes and state type for the shift-add multiplier controller.
// Register, ALU command encodings and the FSM state enum.
package controle_pkg;

  localparam logic [1:0] LIMPARXZ   = 2'b00;
  localparam logic [1:0] CARREGARXZ = 2'b01;
  localparam logic [1:0] MANTERXZ   = 2'b10;

  localparam logic [2:0] LIMPARY    = 3'b000;
  localparam logic [2:0] CARREGARY  = 3'b001;
  localparam logic [2:0] MANTERY    = 3'b010;
  localparam logic [2:0] SESQUERDAY = 3'b011;
  localparam logic [2:0] SDIREITAY  = 3'b100;

  localparam logic SOMAULA = 1'b0;
  localparam logic SUBULA  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_TEST  = 3'd2,
    S_ADD   = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/contador_iter.sv
// Iteration counter: clear, saturating increment, terminal flag.
// Never counts past WIDTH-1.
module contador_iter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  localparam logic [CNT_W-1:0] LAST_V = CNT_W'(WIDTH - 1);

  assign last = (cnt == LAST_V);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc && !last)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/controle_seq.sv
// Moore controller for a shift-add multiplier datapath.
// CONTROLE_SEQ_SIGNED_EN: last ADD subtracts (sign-bit correction).
module controle_seq
  import controle_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             y_lsb,
  output logic [1:0]       auxX,
  output logic [2:0]       auxY,
  output logic [1:0]       auxZ,
  output logic             auxULA,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] iter
);

  state_t state;
  state_t nxt;
  logic   clr;
  logic   inc;
  logic   last;

  // Clearing on the start edge too keeps iter at 0 already in LOAD.
  assign clr = ((state == S_IDLE) && start) || (state == S_LOAD);
  assign inc = (state == S_SHIFT);

  contador_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (inc),
    .cnt   (iter),
    .last  (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= nxt;
  end

  always_comb begin
    nxt    = state;
    auxX   = MANTERXZ;
    auxY   = MANTERY;
    auxZ   = MANTERXZ;
    auxULA = SOMAULA;
    busy   = 1'b1;
    done   = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start)
          nxt = S_LOAD;
      end
      S_LOAD: begin
        auxX = CARREGARXZ;
        auxY = CARREGARY;
        auxZ = LIMPARXZ;
        nxt  = S_TEST;
      end
      S_TEST: begin
        nxt = y_lsb ? S_ADD : S_SHIFT;
      end
      S_ADD: begin
        auxZ = CARREGARXZ;
`ifdef CONTROLE_SEQ_SIGNED_EN
        auxULA = last ? SUBULA : SOMAULA;
`else
        auxULA = SOMAULA;
`endif
        nxt = S_SHIFT;
      end
      S_SHIFT: begin
        auxY = SDIREITAY;
        nxt  = last ? S_DONE : S_TEST;
      end
      S_DONE: begin
        done = 1'b1;
        nxt  = S_IDLE;
      end
      default: begin
        busy = 1'b0;
        nxt  = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/controle_seq.md
CONTROLE_SEQ -- requirements
Module: controle_seq

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits and number of shift-add iterations; legal range 1..64.
REQ-002 Derived localparam: CNT_W, value $clog2(WIDTH) (minimum 1), the iteration counter width.
REQ-003 Port: clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 Port: rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port: start, input, 1, request a new operation; sampled only in IDLE.
REQ-006 Port: y_lsb, input, 1, current multiplier LSB from the Y register.
REQ-007 Port: auxX, output, 2, X register command (LIMPARXZ=00, CARREGARXZ=01, MANTERXZ=10).
REQ-008 Port: auxY, output, 3, Y register command (LIMPARY=000, CARREGARY=001, MANTERY=010, SESQUERDAY=011, SDIREITAY=100).
REQ-009 Port: auxZ, output, 2, Z accumulator command, same encoding as auxX.
REQ-010 Port: auxULA, output, 1, ALU operation (SOMAULA=0, SUBULA=1).
REQ-011 Port: busy, output, 1, high in every state except IDLE.
REQ-012 Port: done, output, 1, one-cycle pulse in DONE.
REQ-013 Port: iter, output, CNT_W, current iteration index.

Function
REQ-014 The FSM SHALL be Moore: all outputs decoded only from the state register and the iteration counter.
REQ-015 The FSM SHALL have exactly six states: IDLE, LOAD, TEST, ADD, SHIFT and DONE.
REQ-016 IDLE outputs SHALL be auxX=MANTERXZ, auxY=MANTERY, auxZ=MANTERXZ, auxULA=SOMAULA, busy=0, done=0.
REQ-017 IDLE SHALL go to LOAD when start=1; otherwise it SHALL stay in IDLE.
REQ-018 LOAD (1 cycle) outputs SHALL be auxX=CARREGARXZ, auxY=CARREGARY, auxZ=LIMPARXZ; iter is cleared to 0; next state is TEST.
REQ-019 TEST (1 cycle) outputs SHALL be all MANTER; next state is ADD if y_lsb=1, otherwise SHIFT.
REQ-020 ADD (1 cycle) outputs SHALL be auxZ=CARREGARXZ, auxULA=SOMAULA, and X/Y MANTER; next state is SHIFT.
REQ-021 SHIFT (1 cycle) outputs SHALL be auxY=SDIREITAY, with X/Z MANTER.
REQ-022 From SHIFT, if iter==WIDTH-1 the FSM SHALL go to DONE; otherwise it SHALL increment iter and go to TEST.
REQ-023 DONE (1 cycle) outputs SHALL be done=1 and all MANTER; next state is IDLE.
REQ-024 Latency from the start-sampling edge to DONE SHALL be 2 + 2*WIDTH + (number of 1 bits in Y) cycles.
REQ-025 start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-026 start held high through DONE SHALL begin a new operation in the cycle after IDLE is re-entered.
REQ-027 For WIDTH=1 the FSM SHALL take the path LOAD, TEST, optional ADD, SHIFT, DONE.
REQ-028 iter SHALL never exceed WIDTH-1 and SHALL not wrap.

Reset
REQ-029 rst_n=0 SHALL force IDLE immediately, asynchronously, and set iter=0.
REQ-030 Outputs SHALL equal the IDLE values while rst_n=0, including reset asserted mid-operation.
REQ-031 The first state change after rst_n deassertion SHALL occur on the first clk edge at which start=1.

Configuration
REQ-032 Macro CONTROLE_SEQ_SIGNED_EN defined: ADD with iter==WIDTH-1 SHALL drive auxULA=SUBULA (two's-complement sign-bit correction).
REQ-033 Macro CONTROLE_SEQ_SIGNED_EN absent: ADD SHALL always drive SOMAULA (unsigned multiply).

Structure
REQ-034 Package controle_pkg SHALL hold the auxX/auxZ codes, the auxY codes, the auxULA codes and the state enum type.
REQ-035 The iteration counter SHALL be a separate sub-module contador_iter (clear, increment, terminal flag).

Verification
REQ-036 WIDTH=8, y_lsb=0 every TEST -> no ADD state; DONE at cycle 18 after start edge; done high for exactly 1 cycle.
REQ-037 WIDTH=8, y_lsb=1 every TEST -> 8 ADD cycles, all SOMAULA without the macro; DONE at cycle 26.
REQ-038 WIDTH=8 with macro, y_lsb pattern of Y=0x80 -> single ADD at iter=7 with auxULA=1.
REQ-039 rst_n pulsed low during ADD at iter=3 -> outputs return to IDLE values within the reset cycle; iter=0; no done pulse.
REQ-040 start held high continuously -> back-to-back operations with exactly one IDLE cycle between DONE and LOAD; start during busy has no effect.
